// File: rtl/pipe_mode_pkg.sv
// ============================================================================
// Module      : pipe_mode_pkg
// Description : Display-mode type, mode sequencing and test-pattern bar colours
//               for pipe_mode_ctrl. PIPE_TESTPAT_EN adds the TESTPAT mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_mode_pkg;

`ifdef PIPE_TESTPAT_EN
    typedef enum logic [1:0] {
        MODE_RAW     = 2'd0,
        MODE_GREY    = 2'd1,
        MODE_EDGE    = 2'd2,
        MODE_TESTPAT = 2'd3
    } mode_e;

    localparam int c_MODE_COUNT = 4;
`else
    typedef enum logic [1:0] {
        MODE_RAW  = 2'd0,
        MODE_GREY = 2'd1,
        MODE_EDGE = 2'd2
    } mode_e;

    localparam int c_MODE_COUNT = 3;
`endif

    localparam logic [11:0] c_BAR_COLOUR_0 = 12'hFFF;
    localparam logic [11:0] c_BAR_COLOUR_1 = 12'hFF0;
    localparam logic [11:0] c_BAR_COLOUR_2 = 12'h0FF;
    localparam logic [11:0] c_BAR_COLOUR_3 = 12'h0F0;
    localparam logic [11:0] c_BAR_COLOUR_4 = 12'hF0F;
    localparam logic [11:0] c_BAR_COLOUR_5 = 12'hF00;
    localparam logic [11:0] c_BAR_COLOUR_6 = 12'h00F;
    localparam logic [11:0] c_BAR_COLOUR_7 = 12'h000;

    function automatic mode_e next_mode(input mode_e m);
        mode_e n;
        case (m)
            MODE_RAW:     n = MODE_GREY;
            MODE_GREY:    n = MODE_EDGE;
`ifdef PIPE_TESTPAT_EN
            MODE_EDGE:    n = MODE_TESTPAT;
            MODE_TESTPAT: n = MODE_RAW;
`else
            MODE_EDGE:    n = MODE_RAW;
`endif
            default:      n = MODE_RAW;
        endcase
        return n;
    endfunction

    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        logic [11:0] c;
        case (idx)
            3'd0:    c = c_BAR_COLOUR_0;
            3'd1:    c = c_BAR_COLOUR_1;
            3'd2:    c = c_BAR_COLOUR_2;
            3'd3:    c = c_BAR_COLOUR_3;
            3'd4:    c = c_BAR_COLOUR_4;
            3'd5:    c = c_BAR_COLOUR_5;
            3'd6:    c = c_BAR_COLOUR_6;
            default: c = c_BAR_COLOUR_7;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : 2-flop synchroniser plus press/release debounce FSM; emits a
//               one-cycle pulse when a press has been stable long enough.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_n,
    output logic o_press
);

    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_BTN_IDLE         = 2'd0;
    localparam logic [1:0] c_BTN_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] c_BTN_HELD         = 2'd2;
    localparam logic [1:0] c_BTN_RELEASE_WAIT = 2'd3;

    logic [1:0]         r_sync;
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_press;
    logic               w_btn_n;

    assign w_btn_n = r_sync[1];
    assign o_press = r_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_state <= c_BTN_IDLE;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn_n};
            r_press <= 1'b0;
            case (r_state)
                c_BTN_IDLE: begin
                    r_cnt <= '0;
                    if (!w_btn_n) r_state <= c_BTN_PRESS_WAIT;
                end
                c_BTN_PRESS_WAIT: begin
                    if (w_btn_n) begin
                        r_state <= c_BTN_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_CNT_MAX) begin
                        r_state <= c_BTN_HELD;
                        r_cnt   <= '0;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_BTN_HELD: begin
                    r_cnt <= '0;
                    if (w_btn_n) r_state <= c_BTN_RELEASE_WAIT;
                end
                c_BTN_RELEASE_WAIT: begin
                    // A low glitch during release means the button is still held.
                    if (!w_btn_n) begin
                        r_state <= c_BTN_HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_CNT_MAX) begin
                        r_state <= c_BTN_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_BTN_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_mode_ctrl.sv
// ============================================================================
// Module      : pipe_mode_ctrl
// Description : Button-driven display-mode selector; switches modes only on
//               frame boundaries. Define PIPE_TESTPAT_EN for the colour-bar mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_mode_ctrl
    import pipe_mode_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int IMG_W           = 640
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_n,
    input  logic        frame_start,
    input  logic [11:0] raw_pixel,
    input  logic [11:0] grey_pixel,
    input  logic [11:0] edge_pixel,
    input  logic        raw_ready,
    input  logic        grey_ready,
    input  logic        edge_ready,
    output logic [11:0] pixel_out,
    output logic        out_ready,
    output logic [1:0]  mode,
    output logic        mode_changed
);

    logic        w_press;
    logic        w_advance;
    mode_e       w_next_mode;
    mode_e       w_sel_mode;
    logic [11:0] w_sel_pixel;
    logic        w_sel_ready;

    mode_e       r_mode;
    logic        r_pending;
    logic        r_mode_changed;
    logic [11:0] r_pixel;
    logic        r_ready;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk     (clk),
        .rst     (rst),
        .i_btn_n (btn_n),
        .o_press (w_press)
    );

    assign w_advance   = frame_start & r_pending;
    assign w_next_mode = next_mode(r_mode);
    // The frame_start pixel already belongs to the new frame, so use the new mode.
    assign w_sel_mode  = w_advance ? w_next_mode : r_mode;

`ifdef PIPE_TESTPAT_EN
    localparam int                 c_COL_W   = $clog2(IMG_W);
    localparam logic [c_COL_W-1:0] c_COL_MAX = c_COL_W'(IMG_W - 1);
    localparam logic [c_COL_W-1:0] c_BAR_W   = c_COL_W'(IMG_W / 8);

    logic [c_COL_W-1:0] r_col;
    logic [c_COL_W-1:0] w_col;
    logic [c_COL_W-1:0] w_bar_full;
    logic [2:0]         w_bar;

    assign w_col      = frame_start ? '0 : r_col;
    assign w_bar_full = w_col / c_BAR_W;
    assign w_bar      = w_bar_full[2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
        end else if (raw_ready) begin
            r_col <= (w_col == c_COL_MAX) ? '0 : w_col + 1'b1;
        end else if (frame_start) begin
            r_col <= '0;
        end
    end
`endif

    always_comb begin
        w_sel_pixel = raw_pixel;
        w_sel_ready = raw_ready;
        case (w_sel_mode)
            MODE_GREY: begin
                w_sel_pixel = grey_pixel;
                w_sel_ready = grey_ready;
            end
            MODE_EDGE: begin
                w_sel_pixel = edge_pixel;
                w_sel_ready = edge_ready;
            end
`ifdef PIPE_TESTPAT_EN
            MODE_TESTPAT: begin
                w_sel_pixel = bar_colour(w_bar);
                w_sel_ready = raw_ready;
            end
`endif
            default: begin
                w_sel_pixel = raw_pixel;
                w_sel_ready = raw_ready;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode         <= MODE_RAW;
            r_pending      <= 1'b0;
            r_mode_changed <= 1'b0;
            r_pixel        <= 12'h000;
            r_ready        <= 1'b0;
        end else begin
            r_mode_changed <= w_advance;
            if (w_advance) r_mode <= w_next_mode;
            // A press landing on the applying frame_start is absorbed; one landing
            // on a frame_start with nothing pending waits for the next frame.
            r_pending      <= w_advance ? 1'b0 : (r_pending | w_press);
            r_pixel        <= w_sel_pixel;
            r_ready        <= w_sel_ready;
        end
    end

    assign pixel_out    = r_pixel;
    assign out_ready    = r_ready;
    assign mode         = r_mode;
    assign mode_changed = r_mode_changed;

endmodule

`default_nettype wire

// File: tb/tb_pipe_mode_ctrl.sv
// ============================================================================
// Module      : tb_pipe_mode_ctrl
// Description : Directed self-checking bench for pipe_mode_ctrl
//               (DEBOUNCE_CYCLES=4; TESTPAT checks only with PIPE_TESTPAT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_mode_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_n;
    logic        frame_start;
    logic [11:0] raw_pixel, grey_pixel, edge_pixel;
    logic        raw_ready, grey_ready, edge_ready;
    logic [11:0] pixel_out;
    logic        out_ready;
    logic [1:0]  mode;
    logic        mode_changed;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_mode_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .IMG_W           (640)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_n        (btn_n),
        .frame_start  (frame_start),
        .raw_pixel    (raw_pixel),
        .grey_pixel   (grey_pixel),
        .edge_pixel   (edge_pixel),
        .raw_ready    (raw_ready),
        .grey_ready   (grey_ready),
        .edge_ready   (edge_ready),
        .pixel_out    (pixel_out),
        .out_ready    (out_ready),
        .mode         (mode),
        .mode_changed (mode_changed)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        btn_n = 1'b0;
        repeat (10) tick();
        btn_n = 1'b1;
        repeat (12) tick();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; btn_n = 1'b1; frame_start = 1'b0;
        raw_pixel = 12'hA01; grey_pixel = 12'hB02; edge_pixel = 12'hC03;
        raw_ready = 1'b1; grey_ready = 1'b1; edge_ready = 1'b1;
        tick(); tick();
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_ready", 32'(out_ready), 32'd0);
        check("rst_pixel", 32'(pixel_out), 32'h000);
        check("rst_changed", 32'(mode_changed), 32'd0);

        rst = 1'b0;
        tick();
        check("raw_pixel", 32'(pixel_out), 32'hA01);
        check("raw_ready", 32'(out_ready), 32'd1);
        raw_ready = 1'b0;
        tick();
        check("raw_ready_only", 32'(out_ready), 32'd0);
        raw_ready = 1'b1;
        tick();

        // clean press, then frame boundary
        press();
        frame();
        check("t1_mode", 32'(mode), 32'd1);
        check("t1_changed", 32'(mode_changed), 32'd1);
        check("t1_pixel", 32'(pixel_out), 32'hB02);
        tick();
        check("t1_pulse_end", 32'(mode_changed), 32'd0);

        // bounce never qualifies
        btn_n = 1'b0; repeat (3) tick();
        btn_n = 1'b1; tick();
        btn_n = 1'b0; repeat (3) tick();
        btn_n = 1'b1; repeat (12) tick();
        frame();
        check("t2_mode", 32'(mode), 32'd1);
        check("t2_changed", 32'(mode_changed), 32'd0);

        // three presses in one frame -> single advance
        press(); press(); press();
        frame();
        check("t3_mode", 32'(mode), 32'd2);
        check("t3_changed", 32'(mode_changed), 32'd1);
        check("t3_pixel", 32'(pixel_out), 32'hC03);
        tick();
        frame();
        check("t3_no_second", 32'(mode), 32'd2);
        check("t3_no_pulse", 32'(mode_changed), 32'd0);

        // press qualifies on the frame_start cycle
        btn_n = 1'b0;
        repeat (7) tick();
        frame();
        check("t4_same_mode", 32'(mode), 32'd2);
        check("t4_same_changed", 32'(mode_changed), 32'd0);
        repeat (5) tick();
        btn_n = 1'b1;
        repeat (12) tick();
        frame();
`ifdef PIPE_TESTPAT_EN
        check("t4_next_mode", 32'(mode), 32'd3);
`else
        check("t4_next_mode", 32'(mode), 32'd0);
`endif
        check("t4_next_changed", 32'(mode_changed), 32'd1);

        // reset while in EDGE with a press pending
        rst = 1'b1; tick(); rst = 1'b0; tick();
        press(); frame(); press(); frame();
        check("t6_in_edge", 32'(mode), 32'd2);
        press();
        rst = 1'b1;
        tick();
        check("t6_rst_mode", 32'(mode), 32'd0);
        check("t6_rst_ready", 32'(out_ready), 32'd0);
        check("t6_rst_changed", 32'(mode_changed), 32'd0);
        rst = 1'b0;
        tick();
        check("t6_resume_raw", 32'(pixel_out), 32'hA01);
        frame();
        check("t6_frame_mode", 32'(mode), 32'd0);
        check("t6_frame_changed", 32'(mode_changed), 32'd0);

`ifdef PIPE_TESTPAT_EN
        // colour bars: pixel index i is visible right after edge i of the frame
        press(); frame(); press(); frame(); press();
        frame();
        check("t5_mode", 32'(mode), 32'd3);
        check("t5_px0", 32'(pixel_out), 32'hFFF);
        check("t5_ready", 32'(out_ready), 32'd1);
        repeat (80) tick();
        check("t5_px80", 32'(pixel_out), 32'hFF0);
        repeat (559) tick();
        check("t5_px639", 32'(pixel_out), 32'h000);
        tick();
        check("t5_px640_wrap", 32'(pixel_out), 32'hFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
